// File: rtl/vdma_wr_arbiter.sv
// Round-robin arbiter sharing one AXI write-burst engine among NCH channel controllers,
// with per-channel auto-incrementing start address and single-cycle resp/done pulses.
module vdma_wr_arbiter #(
  parameter int NCH        = 4,
  parameter int LSIZE      = 9,
  parameter int ADDR_W     = 32,
  parameter int BEAT_BYTES = 16
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic [NCH-1:0]        ch_burst_req,
  input  logic [NCH-1:0]        ch_tail_req,
  input  logic [NCH*LSIZE-1:0]  ch_len,
  input  logic [NCH*ADDR_W-1:0] ch_base,
  input  logic [NCH-1:0]        ch_frame_start,
  input  logic [NCH-1:0]        ch_abort,
  output logic [NCH-1:0]        ch_resp,
  output logic [NCH-1:0]        ch_done,
  output logic                  m_req,
  output logic [LSIZE-1:0]      m_len,
  output logic [ADDR_W-1:0]     m_addr,
  output logic                  m_tail,
  input  logic                  m_ack,
  input  logic                  m_done,
  output logic [2:0]            grant_id
);

  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int BSH = $clog2(BEAT_BYTES);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, GAP} state_t;

  state_t            state;
  logic [IW-1:0]     rr;
  logic [IW-1:0]     g;
  logic [IW-1:0]     sel;
  logic              any_req;
  logic [NCH-1:0]    req_vec;
  logic [ADDR_W-1:0] ptr [NCH];
  logic [ADDR_W-1:0] step;

  assign req_vec = ch_burst_req | ch_tail_req;
  assign step    = ADDR_W'(m_len) << BSH;

  // First requester strictly after the last grant, wrapping modulo NCH.
  always_comb begin
    int j;
    j       = 0;
    sel     = '0;
    any_req = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      j = int'(rr) + k;
      if (j >= NCH) j = j - NCH;
      if (!any_req && req_vec[j]) begin
        any_req = 1'b1;
        sel     = IW'(j);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr       <= '0;
      g        <= '0;
      ch_resp  <= '0;
      ch_done  <= '0;
      m_req    <= 1'b0;
      m_len    <= '0;
      m_addr   <= '0;
      m_tail   <= 1'b0;
      grant_id <= '0;
      for (int i = 0; i < NCH; i++) ptr[i] <= '0;
    end else begin
      ch_resp <= '0;
      ch_done <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            g        <= sel;
            rr       <= sel;
            grant_id <= 3'(sel);
            m_len    <= ch_len[sel*LSIZE +: LSIZE];
            m_addr   <= ptr[sel];
            m_tail   <= ch_tail_req[sel];
            m_req    <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          // An abort racing the ack wins: no resp and no pointer advance.
          if (ch_abort[g]) begin
            m_req <= 1'b0;
            state <= GAP;
          end else if (m_ack) begin
            m_req      <= 1'b0;
            ch_resp[g] <= 1'b1;
            ptr[g]     <= ptr[g] + step;
            if (m_done) begin
              ch_done[g] <= 1'b1;
              state      <= GAP;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (ch_abort[g]) begin
            state <= GAP;
          end else if (m_done) begin
            ch_done[g] <= 1'b1;
            state      <= GAP;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
      // Placed after the FSM so a reload overrides a same-cycle advance.
      for (int i = 0; i < NCH; i++) begin
        if (ch_frame_start[i]) ptr[i] <= ch_base[i*ADDR_W +: ADDR_W];
      end
    end
  end

endmodule

// File: tb/tb_vdma_wr_arbiter.sv
// Scoreboard bench: expected bursts are queued as requests are raised and popped when m_req rises.
module tb_vdma_wr_arbiter;

  logic         clock = 1'b0;
  logic         rst_n;
  logic [3:0]   ch_burst_req, ch_tail_req, ch_frame_start, ch_abort;
  logic [35:0]  ch_len;
  logic [127:0] ch_base;
  logic [3:0]   ch_resp, ch_done;
  logic         m_req, m_tail, m_ack, m_done;
  logic [8:0]   m_len;
  logic [31:0]  m_addr;
  logic [2:0]   grant_id;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         ch;
    logic [31:0] addr;
    logic [8:0]  len;
    logic        tail;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mptr [4];

  vdma_wr_arbiter #(.NCH(4), .LSIZE(9), .ADDR_W(32), .BEAT_BYTES(16)) dut (
    .clock(clock), .rst_n(rst_n),
    .ch_burst_req(ch_burst_req), .ch_tail_req(ch_tail_req),
    .ch_len(ch_len), .ch_base(ch_base),
    .ch_frame_start(ch_frame_start), .ch_abort(ch_abort),
    .ch_resp(ch_resp), .ch_done(ch_done),
    .m_req(m_req), .m_len(m_len), .m_addr(m_addr), .m_tail(m_tail),
    .m_ack(m_ack), .m_done(m_done), .grant_id(grant_id)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  function automatic void push_exp(input int ch, input bit tail, input bit adv);
    exp_t e;
    e.ch   = ch;
    e.addr = mptr[ch];
    e.len  = ch_len[ch*9 +: 9];
    e.tail = tail;
    sb.push_back(e);
    if (adv) mptr[ch] = mptr[ch] + 32'(e.len) * 32'd16;
  endfunction

  function automatic void clear_model();
    for (int i = 0; i < 4; i++) mptr[i] = 32'd0;
  endfunction

  // Engine model: waits for m_req, checks it against the queue head, then acks/completes or aborts.
  // abort_mode: 0 none, 1 abort while in ISSUE, 2 abort while in BUSY.
  task automatic serve(input int ack_dly, input int done_dly, input bit same,
                       input int abort_mode, output int waited);
    exp_t       e;
    logic [3:0] oh;
    waited = 0;
    while (m_req !== 1'b1 && waited < 40) begin
      tick();
      waited++;
    end
    checks++;
    if (m_req !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL req_wait m_req=%b queued=%0d expected m_req=1 with a queued burst", m_req, sb.size());
      return;
    end
    e  = sb.pop_front();
    oh = 4'b0001 << e.ch;
    checks++;
    if (grant_id !== e.ch[2:0] || m_addr !== e.addr || m_len !== e.len || m_tail !== e.tail) begin
      errors++;
      $display("FAIL burst_fields got id=%0d addr=%h len=%0d tail=%b expected id=%0d addr=%h len=%0d tail=%b",
               grant_id, m_addr, m_len, m_tail, e.ch, e.addr, e.len, e.tail);
    end
    repeat (ack_dly) tick();
    checks++;
    if (m_req !== 1'b1) begin
      errors++;
      $display("FAIL req_hold m_req=%b expected 1", m_req);
    end
    if (abort_mode != 1) begin
      m_ack  = 1'b1;
      m_done = same;
      tick();
      m_ack  = 1'b0;
      m_done = 1'b0;
      checks++;
      if (ch_resp !== oh || m_req !== 1'b0 || ch_done !== (same ? oh : 4'b0)) begin
        errors++;
        $display("FAIL resp_pulse resp=%b done=%b m_req=%b expected resp=%b done=%b m_req=0",
                 ch_resp, ch_done, m_req, oh, same ? oh : 4'b0);
      end
      if (!same) begin
        tick();
        checks++;
        if (ch_resp !== 4'b0 || ch_done !== 4'b0) begin
          errors++;
          $display("FAIL resp_single resp=%b done=%b expected 0000 0000", ch_resp, ch_done);
        end
        if (abort_mode == 0) begin
          repeat (done_dly) tick();
          m_done = 1'b1;
          tick();
          m_done = 1'b0;
          checks++;
          if (ch_done !== oh) begin
            errors++;
            $display("FAIL done_pulse done=%b expected %b", ch_done, oh);
          end
        end
      end
    end
    if (abort_mode != 0) begin
      ch_abort[e.ch]     = 1'b1;
      ch_burst_req[e.ch] = 1'b0;
      ch_tail_req[e.ch]  = 1'b0;
      tick();
      ch_abort = 4'b0;
      checks++;
      if (m_req !== 1'b0 || ch_resp !== 4'b0 || ch_done !== 4'b0) begin
        errors++;
        $display("FAIL abort_quiet m_req=%b resp=%b done=%b expected all 0", m_req, ch_resp, ch_done);
      end
      m_done = 1'b1;  // late completion from the engine lands in GAP and must be ignored
    end
    tick();
    m_done = 1'b0;
    checks++;
    if (ch_done !== 4'b0 || ch_resp !== 4'b0 || m_req !== 1'b0) begin
      errors++;
      $display("FAIL gap_quiet done=%b resp=%b m_req=%b expected all 0", ch_done, ch_resp, m_req);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if (m_req !== 1'b0 || m_len !== 9'd0 || m_addr !== 32'd0 || m_tail !== 1'b0 ||
        ch_resp !== 4'b0 || ch_done !== 4'b0 || grant_id !== 3'd0) begin
      errors++;
      $display("FAIL %s req=%b len=%0d addr=%h tail=%b resp=%b done=%b id=%0d expected all 0",
               name, m_req, m_len, m_addr, m_tail, ch_resp, ch_done, grant_id);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    clear_model();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ch_burst_req = '0; ch_tail_req = '0; ch_frame_start = '0; ch_abort = '0;
    ch_len = '0; ch_base = '0; m_ack = 1'b0; m_done = 1'b0;
    repeat (3) tick();
    check_outputs_zero("reset_state");
    rst_n = 1'b1;
    clear_model();
    tick();
    check_outputs_zero("idle_after_reset");
  endtask

  task automatic test_basic();
    int w;
    ch_base[1*32 +: 32] = 32'h0000_1000;
    ch_frame_start[1] = 1'b1;
    tick();
    ch_frame_start = '0;
    mptr[1] = 32'h0000_1000;
    ch_len[1*9 +: 9] = 9'd100;
    ch_burst_req[1] = 1'b1;
    push_exp(1, 1'b0, 1'b1);
    push_exp(1, 1'b0, 1'b1);
    serve(3, 20, 1'b0, 0, w);
    checks++;
    if (w != 1) begin
      errors++;
      $display("FAIL req_latency got %0d cycles expected 1", w);
    end
    serve(0, 2, 1'b0, 0, w);
    ch_burst_req = '0;
    checks++;
    if (w != 1) begin
      errors++;
      $display("FAIL basic_gap got %0d cycles expected 1", w);
    end
  endtask

  task automatic test_round_robin();
    int w;
    int order [5] = '{1, 2, 3, 0, 1};
    do_reset();
    for (int i = 0; i < 4; i++) ch_len[i*9 +: 9] = 9'(i + 1);
    ch_burst_req = 4'b1111;
    for (int i = 0; i < 5; i++) push_exp(order[i], 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      serve(1, 2, 1'b0, 0, w);
      if (i == 4) ch_burst_req = '0;
      checks++;
      if (w != 1) begin
        errors++;
        $display("FAIL rr_spacing burst %0d waited %0d expected 1", i, w);
      end
    end
  endtask

  task automatic test_tail_priority();
    int w;
    ch_len[2*9 +: 9] = 9'd37;
    ch_burst_req[2] = 1'b1;
    ch_tail_req[2]  = 1'b1;
    push_exp(2, 1'b1, 1'b1);
    serve(2, 3, 1'b0, 0, w);
    ch_burst_req = '0;
    ch_tail_req  = '0;
    tick();
    ch_tail_req[2] = 1'b1;
    push_exp(2, 1'b1, 1'b1);
    serve(0, 1, 1'b0, 0, w);
    ch_tail_req = '0;
  endtask

  task automatic test_ack_done_same();
    int w;
    ch_len[3*9 +: 9] = 9'd5;
    ch_burst_req[3] = 1'b1;
    push_exp(3, 1'b0, 1'b1);
    push_exp(3, 1'b0, 1'b1);
    serve(0, 0, 1'b1, 0, w);
    serve(1, 3, 1'b0, 0, w);
    ch_burst_req = '0;
    checks++;
    if (w != 1) begin
      errors++;
      $display("FAIL same_cycle_gap waited %0d expected 1", w);
    end
  endtask

  task automatic test_abort();
    int w;
    ch_len[0*9 +: 9] = 9'd4;
    ch_len[1*9 +: 9] = 9'd6;
    ch_len[2*9 +: 9] = 9'd8;
    ch_burst_req[0] = 1'b1;
    ch_burst_req[1] = 1'b1;
    push_exp(0, 1'b0, 1'b1);
    push_exp(1, 1'b0, 1'b1);
    serve(1, 0, 1'b0, 2, w);
    serve(1, 2, 1'b0, 0, w);
    ch_burst_req = '0;
    checks++;
    if (w != 1) begin
      errors++;
      $display("FAIL abort_next_grant waited %0d expected 1", w);
    end
    tick();
    ch_burst_req[2] = 1'b1;
    push_exp(2, 1'b0, 1'b0);
    serve(2, 0, 1'b0, 1, w);
    tick();
    ch_burst_req[2] = 1'b1;
    push_exp(2, 1'b0, 1'b1);
    serve(0, 1, 1'b0, 0, w);
    ch_burst_req = '0;
  endtask

  task automatic test_wrap();
    int w;
    ch_base[0*32 +: 32] = 32'hFFFF_FFF0;
    ch_frame_start[0] = 1'b1;
    tick();
    ch_frame_start = '0;
    mptr[0] = 32'hFFFF_FFF0;
    ch_len[0*9 +: 9] = 9'd2;
    ch_burst_req[0] = 1'b1;
    push_exp(0, 1'b0, 1'b1);
    push_exp(0, 1'b0, 1'b1);
    serve(0, 1, 1'b0, 0, w);
    serve(0, 1, 1'b0, 0, w);
    ch_burst_req = '0;
  endtask

  task automatic test_reset_mid_busy();
    int w;
    exp_t e;
    ch_len[3*9 +: 9] = 9'd7;
    ch_burst_req[3] = 1'b1;
    push_exp(3, 1'b0, 1'b1);
    w = 0;
    while (m_req !== 1'b1 && w < 40) begin
      tick();
      w++;
    end
    e = sb.pop_front();
    checks++;
    if (m_req !== 1'b1 || m_addr !== e.addr || grant_id !== e.ch[2:0]) begin
      errors++;
      $display("FAIL mid_reset_issue m_req=%b addr=%h id=%0d expected 1 %h %0d",
               m_req, m_addr, grant_id, e.addr, e.ch);
    end
    m_ack = 1'b1;
    tick();
    m_ack = 1'b0;
    tick();
    rst_n = 1'b0;
    ch_burst_req = '0;
    tick();
    check_outputs_zero("mid_busy_reset");
    tick();
    rst_n = 1'b1;
    clear_model();
    ch_len[0*9 +: 9] = 9'd1;
    ch_burst_req[0] = 1'b1;
    push_exp(0, 1'b0, 1'b1);
    serve(0, 1, 1'b0, 0, w);
    ch_burst_req = '0;
    checks++;
    if (w != 1) begin
      errors++;
      $display("FAIL post_reset_latency waited %0d expected 1", w);
    end
    tick();
    ch_burst_req[3] = 1'b1;
    push_exp(3, 1'b0, 1'b1);
    serve(0, 1, 1'b0, 0, w);
    ch_burst_req = '0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_tail_priority();
    test_ack_done_same();
    test_abort();
    test_wrap();
    test_reset_mid_busy();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
